core_dbus_bridge: RTL and testbench
===================================

Name: core_dbus_bridge

Overview:
- Sits directly downstream of the core's data-memory port (the MEM&WB stage request lines) and converts the core's level-held request / single-cycle-ack protocol into a Wishbone-classic master cycle on the system data bus.
- Builds the 24-bit bus word address from the 16-bit address plus the long-mode high byte.
- Registers the read data and enforces a bus timeout.
- Reports bus errors and timeouts back to the core as a one-cycle exception flag alongside the ack.

Parameters:
- RW, 16, data/address word width (matches core `RW).
- SEL_W, 2, byte-select width (matches `ADDR_BYTES).
- TIMEOUT, 255, cycles in BUS state before a forced error completion; range 1..255.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_mem_req  in  1  core request, held high and stable until ack
- i_mem_we  in  1  1 = write, 0 = read
- i_mem_addr  in  RW  core word address
- i_mem_data  in  RW  write data
- i_mem_sel  in  SEL_W  byte enables
- i_mem_long  in  1  long-address mode
- i_mem_addr_high  in  8  high address byte, used only when i_mem_long = 1
- o_mem_data  out  RW  read data to core
- o_mem_ack  out  1  one-cycle completion pulse
- o_mem_err  out  1  error qualifier, valid only when o_mem_ack = 1
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_adr  out  24  bus word address
- wb_dat_o  out  RW  bus write data
- wb_sel  out  SEL_W  bus byte select
- wb_dat_i  in  RW  bus read data
- wb_ack  in  1  bus ack
- wb_err  in  1  bus error

Behaviour:
- Reset (synchronous, i_rst = 1 at a clock edge):
  - state = IDLE; timeout counter = 0.
  - All outputs 0: wb_cyc, wb_stb, wb_we, o_mem_ack, o_mem_err, wb_adr, wb_dat_o, wb_sel, o_mem_data.
  - Reset asserted mid-transaction drops wb_cyc/wb_stb on that edge. No ack is ever produced for the aborted request.
- State IDLE:
  - If i_mem_req = 1, latch the request into registers and go to BUS:
    - wb_adr = i_mem_long ? {i_mem_addr_high, i_mem_addr} : {8'h00, i_mem_addr}
    - wb_we = i_mem_we, wb_dat_o = i_mem_data, wb_sel = i_mem_sel
    - set wb_cyc = wb_stb = 1; counter = 0
  - Otherwise stay in IDLE.
- State BUS:
  - Bus outputs are held constant.
  - wb_ack = 1:
    - drop cyc/stb
    - o_mem_data = we ? 0 : wb_dat_i
    - go to RESP with err = 0
  - wb_err = 1, or wb_ack and wb_err together:
    - treated as error: drop cyc/stb, o_mem_data = 0
    - go to RESP with err = 1
  - counter == TIMEOUT-1 with no ack/err: same as error (err = 1, data 0).
  - Otherwise counter increments.
- State RESP:
  - o_mem_ack = 1 and o_mem_err = err for exactly this one cycle; next state IDLE.
  - o_mem_data stays stable until the next completion.
- Latency:
  - Request sampled at edge N gives cyc high at N+1.
  - Zero-wait-state bus (ack in the first BUS cycle) gives o_mem_ack high in cycle N+2.
  - Minimum 3 cycles per request; back-to-back requests are spaced at least 3 cycles apart.
- Core-side rule: in the cycle after o_mem_ack, the core either drops i_mem_req or presents a new request. IDLE samples that cycle, so a held request is never issued twice.
- Request inputs are ignored outside IDLE; changes while in BUS have no effect on the bus.
- wb_stb always equals wb_cyc (no pipelining, one outstanding access).
- A wb_ack/wb_err arriving in IDLE or RESP is ignored.

Test Plan:
- Zero-wait read: req = 1, we = 0, addr = 16'h1234, long = 0; bus acks in the first BUS cycle with dat = 16'hBEEF -> wb_adr = 24'h001234; o_mem_ack pulses 2 cycles after the req edge with o_mem_data = 16'hBEEF and err = 0.
- Long write: long = 1, addr_high = 8'hA5, addr = 16'h0010, data = 16'h5A5A, sel = 2'b01; bus acks after 3 wait cycles -> wb_adr = 24'hA50010, wb_we = 1, wb_dat_o = 16'h5A5A, wb_sel = 2'b01 stable throughout; single ack, err = 0.
- Bus error: wb_err asserted in the 2nd BUS cycle -> cyc drops, o_mem_ack = 1 with o_mem_err = 1 and o_mem_data = 0.
- Timeout with TIMEOUT = 4 and the bus never responding -> cyc high for exactly 4 cycles, then ack with err = 1.
- Held req: req kept high for 2 cycles after ack -> exactly two bus cycles issued, not three; new address used for the second.
- Reset while in BUS -> next cycle wb_cyc = 0, no o_mem_ack; a following request completes normally.

Source files
------------

// File: rtl/core_dbus_bridge.sv
// core_dbus_bridge: converts the core data-memory request/ack handshake into a
// single-outstanding Wishbone-classic master cycle, with a bus timeout and
// error reporting through a one-cycle ack/err pulse back to the core.
module core_dbus_bridge #(
  parameter int RW      = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mem_req,
  input  logic             i_mem_we,
  input  logic [RW-1:0]    i_mem_addr,
  input  logic [RW-1:0]    i_mem_data,
  input  logic [SEL_W-1:0] i_mem_sel,
  input  logic             i_mem_long,
  input  logic [7:0]       i_mem_addr_high,
  output logic [RW-1:0]    o_mem_data,
  output logic             o_mem_ack,
  output logic             o_mem_err,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [23:0]      wb_adr,
  output logic [RW-1:0]    wb_dat_o,
  output logic [SEL_W-1:0] wb_sel,
  input  logic [RW-1:0]    wb_dat_i,
  input  logic             wb_ack,
  input  logic             wb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last counter value allowed in BUS before the access is forced to fail.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;

  // Request/bus FSM; every output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_dat_o   <= '0;
      wb_sel     <= '0;
      o_mem_ack  <= 1'b0;
      o_mem_err  <= 1'b0;
      o_mem_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_mem_ack <= 1'b0;
          o_mem_err <= 1'b0;
          if (i_mem_req) begin
            wb_adr   <= i_mem_long ? {i_mem_addr_high, i_mem_addr[15:0]}
                                   : {8'h00, i_mem_addr[15:0]};
            wb_we    <= i_mem_we;
            wb_dat_o <= i_mem_data;
            wb_sel   <= i_mem_sel;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            cnt      <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // Error wins over a simultaneous ack; a timeout only fires when the
          // bus gave no response at all in the final allowed cycle.
          if (wb_err || (!wb_ack && cnt == CNT_LAST)) begin
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            o_mem_data <= '0;
            o_mem_ack  <= 1'b1;
            o_mem_err  <= 1'b1;
            state      <= RESP;
          end else if (wb_ack) begin
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            o_mem_data <= wb_we ? '0 : wb_dat_i;
            o_mem_ack  <= 1'b1;
            o_mem_err  <= 1'b0;
            state      <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          o_mem_ack <= 1'b0;
          o_mem_err <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_dbus_bridge.sv
// Bench for core_dbus_bridge: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the bridge.
module tb_core_dbus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [15:0] i_mem_addr;
  logic [15:0] i_mem_data;
  logic [1:0]  i_mem_sel;
  logic        i_mem_long;
  logic [7:0]  i_mem_addr_high;
  logic [15:0] o_mem_data;
  logic        o_mem_ack;
  logic        o_mem_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel;
  logic [15:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_data = '0;

  core_dbus_bridge #(.RW(16), .SEL_W(2), .TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_mem_req      (i_mem_req),
    .i_mem_we       (i_mem_we),
    .i_mem_addr     (i_mem_addr),
    .i_mem_data     (i_mem_data),
    .i_mem_sel      (i_mem_sel),
    .i_mem_long     (i_mem_long),
    .i_mem_addr_high(i_mem_addr_high),
    .o_mem_data     (o_mem_data),
    .o_mem_ack      (o_mem_ack),
    .o_mem_err      (o_mem_err),
    .wb_cyc         (wb_cyc),
    .wb_stb         (wb_stb),
    .wb_we          (wb_we),
    .wb_adr         (wb_adr),
    .wb_dat_o       (wb_dat_o),
    .wb_sel         (wb_sel),
    .wb_dat_i       (wb_dat_i),
    .wb_ack         (wb_ack),
    .wb_err         (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core access. kind: 0 ack, 1 err, 2 ack+err, 3 bus silent.
  // wt is the BUS cycle index (0-based) in which the bus responds.
  // Returns at the mid-cycle point after the ack cycle, request still driven.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] data,
                         input logic [1:0] sel, input logic lng, input logic [7:0] hi,
                         input int wt, input int kind, input logic [15:0] rd);
    logic [23:0] eadr;
    logic        responded;
    logic        eerr;
    logic [15:0] edata;
    int          done_c;
    eadr      = lng ? {hi, addr} : {8'h00, addr};
    responded = (kind != 3) && (wt < TO);
    done_c    = responded ? wt : TO - 1;
    eerr      = responded ? (kind != 0) : 1'b1;
    edata     = (eerr || we) ? 16'h0000 : rd;
    i_mem_req = 1'b1; i_mem_we = we; i_mem_addr = addr; i_mem_data = data;
    i_mem_sel = sel; i_mem_long = lng; i_mem_addr_high = hi;
    wb_ack = 1'b0; wb_err = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      check("bus_cyc",  32'(wb_cyc), 32'(1'b1));
      check("bus_stb",  32'(wb_stb), 32'(1'b1));
      check("bus_adr",  32'(wb_adr), 32'(eadr));
      check("bus_we",   32'(wb_we), 32'(we));
      check("bus_dato", 32'(wb_dat_o), 32'(data));
      check("bus_sel",  32'(wb_sel), 32'(sel));
      check("bus_noack", 32'(o_mem_ack), 32'(1'b0));
      // Request fields are already captured; disturbing them must not matter.
      i_mem_addr = 16'($urandom); i_mem_data = 16'($urandom);
      i_mem_sel = 2'($urandom); i_mem_long = 1'($urandom);
      i_mem_addr_high = 8'($urandom); i_mem_we = 1'($urandom);
      if (c == wt && kind != 3) begin
        wb_ack = (kind != 1); wb_err = (kind != 0); wb_dat_i = rd;
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = 16'($urandom);
      end
    end
    @(negedge clk);
    check("resp_ack",  32'(o_mem_ack), 32'(1'b1));
    check("resp_err",  32'(o_mem_err), 32'(eerr));
    check("resp_data", 32'(o_mem_data), 32'(edata));
    check("resp_cyc",  32'(wb_cyc), 32'(1'b0));
    check("resp_stb",  32'(wb_stb), 32'(1'b0));
    exp_data = edata;
    // Stray responses while in RESP must be ignored.
    wb_ack = 1'($urandom); wb_err = 1'($urandom); wb_dat_i = 16'($urandom);
    @(negedge clk);
    check("post_ack",  32'(o_mem_ack), 32'(1'b0));
    check("post_cyc",  32'(wb_cyc), 32'(1'b0));
    check("post_data", 32'(o_mem_data), 32'(exp_data));
    wb_ack = 1'b0; wb_err = 1'b0;
  endtask

  // Core idle for n cycles, with stray bus responses that must be ignored.
  task automatic idle(input int n);
    i_mem_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      wb_ack = 1'($urandom); wb_err = 1'($urandom); wb_dat_i = 16'($urandom);
      @(negedge clk);
      check("idle_cyc",  32'(wb_cyc), 32'(1'b0));
      check("idle_ack",  32'(o_mem_ack), 32'(1'b0));
      check("idle_data", 32'(o_mem_data), 32'(exp_data));
    end
    wb_ack = 1'b0; wb_err = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_addr = '0; i_mem_data = '0;
    i_mem_sel = '0; i_mem_long = 1'b0; i_mem_addr_high = '0;
    wb_dat_i = 16'hFFFF; wb_ack = 1'b1; wb_err = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cyc",  32'(wb_cyc), 32'(1'b0));
    check("rst_stb",  32'(wb_stb), 32'(1'b0));
    check("rst_we",   32'(wb_we), 32'(1'b0));
    check("rst_adr",  32'(wb_adr), 32'(24'h0));
    check("rst_dato", 32'(wb_dat_o), 32'(16'h0));
    check("rst_sel",  32'(wb_sel), 32'(2'b00));
    check("rst_ack",  32'(o_mem_ack), 32'(1'b0));
    check("rst_err",  32'(o_mem_err), 32'(1'b0));
    check("rst_data", 32'(o_mem_data), 32'(16'h0));
    i_rst = 1'b0;
    idle(2);

    // Zero-wait read.
    run_txn(1'b0, 16'h1234, 16'h0000, 2'b11, 1'b0, 8'hFF, 0, 0, 16'hBEEF);
    idle(1);
    // Long write, 3 wait cycles (ack lands on the last cycle before timeout).
    run_txn(1'b1, 16'h0010, 16'h5A5A, 2'b01, 1'b1, 8'hA5, 3, 0, 16'h1111);
    idle(1);
    // Bus error in the 2nd BUS cycle.
    run_txn(1'b0, 16'h4000, 16'h0000, 2'b10, 1'b0, 8'h00, 1, 1, 16'hCAFE);
    idle(1);
    // Silent bus: timeout.
    run_txn(1'b0, 16'h7777, 16'h0000, 2'b11, 1'b1, 8'h12, 0, 3, 16'h0000);
    idle(1);
    // Simultaneous ack and err.
    run_txn(1'b0, 16'h0042, 16'h0000, 2'b11, 1'b0, 8'h00, 2, 2, 16'h9999);
    idle(1);
    // Held request: a new request follows the ack directly; exactly two accesses.
    run_txn(1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 8'h00, 0, 0, 16'hA001);
    run_txn(1'b0, 16'h0200, 16'h0000, 2'b11, 1'b0, 8'h00, 1, 0, 16'hA002);
    idle(3);

    // Reset in the middle of a bus access.
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 16'h3333; i_mem_long = 1'b0;
    @(negedge clk);
    check("mid_cyc_before", 32'(wb_cyc), 32'(1'b1));
    i_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cyc",  32'(wb_cyc), 32'(1'b0));
    check("mid_rst_stb",  32'(wb_stb), 32'(1'b0));
    check("mid_rst_ack",  32'(o_mem_ack), 32'(1'b0));
    check("mid_rst_data", 32'(o_mem_data), 32'(16'h0));
    i_rst = 1'b0;
    exp_data = 16'h0000;
    idle(3);
    run_txn(1'b0, 16'h5555, 16'h0000, 2'b11, 1'b0, 8'h00, 1, 0, 16'h7E57);
    idle(1);

    // Randomized traffic, sometimes back-to-back.
    for (int t = 0; t < 60; t++) begin
      int wt;
      int kind;
      wt   = int'($urandom_range(0, 6));
      kind = int'($urandom_range(0, 9));
      kind = (kind < 6) ? 0 : (kind < 8) ? 1 : (kind < 9) ? 2 : 3;
      run_txn(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
              8'($urandom), wt, kind, 16'($urandom));
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
